// File: rtl/result_tx_scheduler.sv
// Serialises SMA/EMA results into 3-byte UART frames (tag, LSB, MSB), one pending
// slot per channel, round-robin arbitration on ties and sticky per-channel drop flags.
module result_tx_scheduler #(
  parameter logic [7:0] TAG_SMA = 8'hA1,
  parameter logic [7:0] TAG_EMA = 8'hA2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sma_valid,
  input  logic [15:0] sma_result,
  input  logic        ema_valid,
  input  logic [15:0] ema_result,
  input  logic        tx_ready,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        sma_ovf,
  output logic        ema_ovf,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TAG    = 3'd1;
  localparam logic [2:0] ST_HOLD_T = 3'd2;
  localparam logic [2:0] ST_LSB    = 3'd3;
  localparam logic [2:0] ST_HOLD_L = 3'd4;
  localparam logic [2:0] ST_MSB    = 3'd5;
  localparam logic [2:0] ST_HOLD_M = 3'd6;

  localparam logic CH_SMA = 1'b0;
  localparam logic CH_EMA = 1'b1;

  logic [2:0]  state_q, state_d;
  logic        sma_pend_q, sma_pend_d;
  logic        ema_pend_q, ema_pend_d;
  logic [15:0] sma_word_q, sma_word_d;
  logic [15:0] ema_word_q, ema_word_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] frame_word_q, frame_word_d;
  logic [7:0]  tag_q, tag_d;
  logic        tx_send_q, tx_send_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        sma_ovf_q, sma_ovf_d;
  logic        ema_ovf_q, ema_ovf_d;
  logic [15:0] frames_sent_q, frames_sent_d;
  logic        grant_sma, grant_ema;
  logic        sma_pend_left, ema_pend_left;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    frame_word_d  = frame_word_q;
    tag_d         = tag_q;
    tx_send_d     = 1'b0;
    tx_data_d     = tx_data_q;
    frames_sent_d = frames_sent_q;
    grant_sma     = 1'b0;
    grant_ema     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // SMA wins a tie only when EMA held the previous grant
        if (sma_pend_q && (!ema_pend_q || last_grant_q == CH_EMA)) begin
          grant_sma = 1'b1;
        end else if (ema_pend_q) begin
          grant_ema = 1'b1;
        end
        if (grant_sma) begin
          frame_word_d = sma_word_q;
          tag_d        = TAG_SMA;
          last_grant_d = CH_SMA;
          state_d      = ST_TAG;
        end else if (grant_ema) begin
          frame_word_d = ema_word_q;
          tag_d        = TAG_EMA;
          last_grant_d = CH_EMA;
          state_d      = ST_TAG;
        end
      end
      ST_TAG: begin
        if (tx_ready) begin
          tx_send_d = 1'b1;
          tx_data_d = tag_q;
          state_d   = ST_HOLD_T;
        end
      end
      ST_HOLD_T: state_d = ST_LSB;
      ST_LSB: begin
        if (tx_ready) begin
          tx_send_d = 1'b1;
          tx_data_d = frame_word_q[7:0];
          state_d   = ST_HOLD_L;
        end
      end
      ST_HOLD_L: state_d = ST_MSB;
      ST_MSB: begin
        if (tx_ready) begin
          tx_send_d = 1'b1;
          tx_data_d = frame_word_q[15:8];
          state_d   = ST_HOLD_M;
        end
      end
      ST_HOLD_M: begin
        frames_sent_d = frames_sent_q + 16'd1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A slot granted on this edge is free again, so a same-edge strobe refills it
  always_comb begin
    sma_pend_left = sma_pend_q & ~grant_sma;
    ema_pend_left = ema_pend_q & ~grant_ema;
    sma_pend_d    = sma_pend_left;
    ema_pend_d    = ema_pend_left;
    sma_word_d    = sma_word_q;
    ema_word_d    = ema_word_q;
    sma_ovf_d     = sma_ovf_q;
    ema_ovf_d     = ema_ovf_q;
    if (sma_valid) begin
      if (sma_pend_left) begin
        sma_ovf_d = 1'b1;
      end else begin
        sma_pend_d = 1'b1;
        sma_word_d = sma_result;
      end
    end
    if (ema_valid) begin
      if (ema_pend_left) begin
        ema_ovf_d = 1'b1;
      end else begin
        ema_pend_d = 1'b1;
        ema_word_d = ema_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sma_pend_q    <= 1'b0;
      ema_pend_q    <= 1'b0;
      sma_word_q    <= 16'h0000;
      ema_word_q    <= 16'h0000;
      last_grant_q  <= CH_EMA;
      frame_word_q  <= 16'h0000;
      tag_q         <= 8'h00;
      tx_send_q     <= 1'b0;
      tx_data_q     <= 8'h00;
      sma_ovf_q     <= 1'b0;
      ema_ovf_q     <= 1'b0;
      frames_sent_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      sma_pend_q    <= sma_pend_d;
      ema_pend_q    <= ema_pend_d;
      sma_word_q    <= sma_word_d;
      ema_word_q    <= ema_word_d;
      last_grant_q  <= last_grant_d;
      frame_word_q  <= frame_word_d;
      tag_q         <= tag_d;
      tx_send_q     <= tx_send_d;
      tx_data_q     <= tx_data_d;
      sma_ovf_q     <= sma_ovf_d;
      ema_ovf_q     <= ema_ovf_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign sma_ovf     = sma_ovf_q;
  assign ema_ovf     = ema_ovf_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_result_tx_scheduler.sv
// Bench for result_tx_scheduler: directed scenarios against fixed byte sequences, then
// random traffic against a byte-queue model of the frame scheduler.
module tb_result_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sma_valid = 1'b0;
  logic [15:0] sma_result = 16'h0000;
  logic        ema_valid = 1'b0;
  logic [15:0] ema_result = 16'h0000;
  logic        tx_ready = 1'b1;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic        sma_ovf;
  logic        ema_ovf;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_q[$];
  int         consec_cnt = 0;
  logic       prev_send = 1'b0;

  // Reference model: slots, and the frame in flight as a queue of three bytes
  bit          m_pend[2];
  logic [15:0] m_word[2];
  bit          m_ovf[2];
  int          m_last;
  bit          m_busy;
  logic [7:0]  m_bytes[3];
  int          m_idx;
  bit          m_hold;
  bit          m_send;
  logic [7:0]  m_data;
  logic [15:0] m_frames;

  result_tx_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sma_valid   (sma_valid),
    .sma_result  (sma_result),
    .ema_valid   (ema_valid),
    .ema_result  (ema_result),
    .tx_ready    (tx_ready),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .busy        (busy),
    .sma_ovf     (sma_ovf),
    .ema_ovf     (ema_ovf),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int g;
    if (!reset_n) begin
      m_pend[0] = 0; m_pend[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
      m_last = 1; m_busy = 0; m_idx = 0; m_hold = 0;
      m_send = 0; m_data = 8'h00; m_frames = 16'h0000;
      return;
    end
    g = -1;
    m_send = 0;
    if (!m_busy) begin
      if (m_pend[0] && m_pend[1]) g = (m_last == 0) ? 1 : 0;
      else if (m_pend[0]) g = 0;
      else if (m_pend[1]) g = 1;
      if (g >= 0) begin
        m_busy = 1;
        m_bytes[0] = (g == 0) ? 8'hA1 : 8'hA2;
        m_bytes[1] = m_word[g][7:0];
        m_bytes[2] = m_word[g][15:8];
        m_idx = 0; m_hold = 0; m_pend[g] = 0; m_last = g;
      end
    end else if (m_hold) begin
      m_hold = 0;
      if (m_idx == 3) begin
        m_busy = 0;
        m_frames = m_frames + 16'd1;
      end
    end else if (tx_ready) begin
      m_send = 1;
      m_data = m_bytes[m_idx];
      m_idx++;
      m_hold = 1;
    end
    if (sma_valid) begin
      if (m_pend[0]) m_ovf[0] = 1;
      else begin m_pend[0] = 1; m_word[0] = sma_result; end
    end
    if (ema_valid) begin
      if (m_pend[1]) m_ovf[1] = 1;
      else begin m_pend[1] = 1; m_word[1] = ema_result; end
    end
  endtask

  // One clock: model advances with the sampled inputs, strobes drop, sent bytes are captured
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    sma_valid = 1'b0;
    ema_valid = 1'b0;
    if (tx_send) begin
      cap_q.push_back(tx_data);
      $display("tx byte %02h frames_sent=%0d", tx_data, frames_sent);
    end
    if (tx_send && prev_send) consec_cnt++;
    prev_send = tx_send;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_until(input int nbytes);
    for (int n = 0; n < 400; n++) begin
      if (cap_q.size() >= nbytes && !busy) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sma_valid = 1'b1;
    sma_result = 16'hBEEF;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got=%0h exp=0", tx_send); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%02h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (sma_ovf !== 1'b0 || ema_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0h%0h exp=00", sma_ovf, ema_ovf); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL reset_frames got=%0h exp=0", frames_sent); end
    cap_q.delete();
    for (int i = 0; i < 12; i++) tick();
    checks++; if (cap_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_strobe_ignored got_bytes=%0d busy=%0h exp=0/0", cap_q.size(), busy); end
  endtask

  task automatic test_single_frame();
    logic       exp_send[8];
    logic [7:0] exp_data[8];
    exp_send = '{0, 0, 1, 0, 1, 0, 1, 0};
    exp_data = '{8'h00, 8'h00, 8'hA1, 8'hA1, 8'h34, 8'h34, 8'h12, 8'h12};
    do_reset();
    tx_ready = 1'b1;
    sma_valid = 1'b1;
    sma_result = 16'h1234;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (tx_send !== exp_send[i] || tx_data !== exp_data[i]) begin
        errors++; $display("FAIL single_edge_k+%0d got=%0h/%02h exp=%0h/%02h", i, tx_send, tx_data, exp_send[i], exp_data[i]);
      end
      checks++; if (busy !== (i <= 6)) begin errors++; $display("FAIL single_busy_k+%0d got=%0h exp=%0h", i, busy, (i <= 6)); end
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames got=%0d exp=1", frames_sent); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    exp_q = '{8'hA1, 8'h11, 8'h11, 8'hA2, 8'h22, 8'h22,
              8'hA1, 8'h33, 8'h33, 8'hA2, 8'h44, 8'h44,
              8'hA1, 8'h55, 8'h55,
              8'hA2, 8'h77, 8'h77, 8'hA1, 8'h66, 8'h66};
    do_reset();
    tx_ready = 1'b1;
    cap_q.delete();
    consec_cnt = 0;
    sma_valid = 1'b1; sma_result = 16'h1111; ema_valid = 1'b1; ema_result = 16'h2222;
    tick();
    run_until(6);
    sma_valid = 1'b1; sma_result = 16'h3333; ema_valid = 1'b1; ema_result = 16'h4444;
    tick();
    run_until(12);
    sma_valid = 1'b1; sma_result = 16'h5555;
    tick();
    run_until(15);
    sma_valid = 1'b1; sma_result = 16'h6666; ema_valid = 1'b1; ema_result = 16'h7777;
    tick();
    run_until(21);
    checks++; if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rr_byte_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte_%0d got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
      end
    end
    checks++; if (frames_sent !== 16'd7) begin errors++; $display("FAIL rr_frames got=%0d exp=7", frames_sent); end
    checks++; if (consec_cnt != 0) begin errors++; $display("FAIL rr_back_to_back_send got=%0d exp=0", consec_cnt); end
    checks++; if (sma_ovf !== 1'b0 || ema_ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf got=%0h%0h exp=00", sma_ovf, ema_ovf); end
  endtask

  task automatic test_stall();
    do_reset();
    tx_ready = 1'b1;
    sma_valid = 1'b1;
    sma_result = 16'hABCD;
    tick();
    tick();
    tick();
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hA1) begin errors++; $display("FAIL stall_tag got=%0h/%02h exp=1/a1", tx_send, tx_data); end
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (tx_send !== 1'b0 || tx_data !== 8'hA1 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_cycle_%0d got=%0h/%02h/%0h exp=0/a1/1", i, tx_send, tx_data, busy);
      end
    end
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hCD) begin errors++; $display("FAIL stall_lsb got=%0h/%02h exp=1/cd", tx_send, tx_data); end
    tick();
    checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL stall_hold_l got=%0h exp=0", tx_send); end
    tick();
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hAB) begin errors++; $display("FAIL stall_msb got=%0h/%02h exp=1/ab", tx_send, tx_data); end
    tick();
    checks++; if (busy !== 1'b0 || frames_sent !== 16'd1) begin errors++; $display("FAIL stall_end got=%0h/%0d exp=0/1", busy, frames_sent); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    exp_q = '{8'hA1, 8'h01, 8'h00, 8'hA1, 8'h02, 8'h00};
    do_reset();
    tx_ready = 1'b1;
    cap_q.delete();
    sma_valid = 1'b1; sma_result = 16'h0001; tick();
    sma_valid = 1'b1; sma_result = 16'h0002; tick();
    checks++; if (sma_ovf !== 1'b0) begin errors++; $display("FAIL ovf_same_edge_grant got=%0h exp=0", sma_ovf); end
    sma_valid = 1'b1; sma_result = 16'h0003; tick();
    checks++; if (sma_ovf !== 1'b1 || ema_ovf !== 1'b0) begin errors++; $display("FAIL ovf_flag got=%0h%0h exp=10", sma_ovf, ema_ovf); end
    run_until(6);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_byte_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte_%0d got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
      end
    end
    checks++; if (sma_ovf !== 1'b1 || frames_sent !== 16'd2) begin errors++; $display("FAIL ovf_sticky got=%0h/%0d exp=1/2", sma_ovf, frames_sent); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    tx_ready = 1'b1;
    sma_valid = 1'b1; sma_result = 16'h5A5A; ema_valid = 1'b1; ema_result = 16'hC3C3;
    tick();
    ema_valid = 1'b1; ema_result = 16'h9999;
    tick();
    tick();
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hA1 || ema_ovf !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got=%0h/%02h/%0h exp=1/a1/1", tx_send, tx_data, ema_ovf);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (tx_send !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got=%0h/%02h/%0h exp=0/00/0", tx_send, tx_data, busy);
    end
    checks++; if (sma_ovf !== 1'b0 || ema_ovf !== 1'b0 || frames_sent !== 16'd0) begin
      errors++; $display("FAIL midrst_state got=%0h%0h/%0d exp=00/0", sma_ovf, ema_ovf, frames_sent);
    end
    cap_q.delete();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (cap_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_bytes got=%0d/%0h exp=0/0", cap_q.size(), busy); end
    sma_valid = 1'b1; sma_result = 16'h1357;
    tick();
    run_until(3);
    checks++; if (cap_q.size() != 3) begin
      errors++; $display("FAIL midrst_next_count got=%0d exp=3", cap_q.size());
    end else begin
      checks++; if (cap_q[0] !== 8'hA1 || cap_q[1] !== 8'h57 || cap_q[2] !== 8'h13) begin
        errors++; $display("FAIL midrst_next_frame got=%02h %02h %02h exp=a1 57 13", cap_q[0], cap_q[1], cap_q[2]);
      end
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL midrst_frames got=%0d exp=1", frames_sent); end
  endtask

  task automatic test_wrap();
    do_reset();
    tx_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cap_q.delete();
      sma_valid = 1'b1; sma_result = 16'(f);
      tick();
      run_until(3);
    end
    checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL wrap_fast_frames got=%0d exp=3", frames_sent); end
    // Stand in for the remaining frames of a full 65535-frame preload
    force dut.frames_sent_q = 16'hFFFF;
    #1;
    release dut.frames_sent_q;
    m_frames = 16'hFFFF;
    tick();
    checks++; if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%0h exp=ffff", frames_sent); end
    cap_q.delete();
    ema_valid = 1'b1; ema_result = 16'h8001;
    tick();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (frames_sent !== 16'hFFFF || busy !== 1'b1) begin errors++; $display("FAIL wrap_mid got=%0h/%0h exp=ffff/1", frames_sent, busy); end
    tick();
    checks++; if (frames_sent !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL wrap_zero got=%0h/%0h exp=0/0", frames_sent, busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset_n    = ($urandom_range(0, 799) != 0);
      sma_valid  = ($urandom_range(0, 5) == 0);
      sma_result = 16'($urandom);
      ema_valid  = ($urandom_range(0, 6) == 0);
      ema_result = 16'($urandom);
      tx_ready   = ($urandom_range(0, 9) < 7);
      tick();
      checks++; if (tx_send !== m_send || tx_data !== m_data) begin
        errors++; $display("FAIL rand_tx cyc=%0d got=%0h/%02h exp=%0h/%02h", i, tx_send, tx_data, m_send, m_data);
      end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%0h exp=%0h", i, busy, m_busy); end
      checks++; if (sma_ovf !== m_ovf[0] || ema_ovf !== m_ovf[1]) begin
        errors++; $display("FAIL rand_ovf cyc=%0d got=%0h%0h exp=%0h%0h", i, sma_ovf, ema_ovf, m_ovf[0], m_ovf[1]);
      end
      checks++; if (frames_sent !== m_frames) begin errors++; $display("FAIL rand_frames cyc=%0d got=%0d exp=%0d", i, frames_sent, m_frames); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_overflow();
    test_reset_mid_frame();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
